// File: rtl/prog_counter_n.sv
// Programmable up/down counter with step, inclusive limit, load/clear,
// wrap or one-shot modes, a terminal-count pulse and a sticky done flag.
module prog_counter_n #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              one_shot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done
);

  // One guard bit above the wider operand, so count+step never aliases.
  localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [EXT_W-1:0] count_x, step_x, limit_x, sum_x, diff_x;

  assign count_x = EXT_W'(count_q);
  assign step_x  = EXT_W'(step);
  assign limit_x = EXT_W'(limit);
  assign sum_x   = count_x + step_x;
  assign diff_x  = count_x - step_x;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      done_d  = 1'b0;
    end else if (en && (step != '0) && !done_q) begin
      if (up) begin
        if (sum_x <= limit_x) begin
          count_d = WIDTH'(sum_x);
        end else begin
          tc_d = 1'b1;
          if (one_shot) begin
            count_d = limit;
            done_d  = 1'b1;
          end else begin
            count_d = '0;
          end
        end
      end else begin
        if (count_x >= step_x) begin
          count_d = WIDTH'(diff_x);
        end else begin
          tc_d = 1'b1;
          if (one_shot) begin
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            count_d = limit;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prog_counter_n.sv
// Scoreboard bench for prog_counter_n: stimulus pushes model predictions,
// a monitor pops and compares them one clock later.
module tb_prog_counter_n;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int MAXV   = (1 << WIDTH) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0, clr = 1'b0, load = 1'b0, up = 1'b0, one_shot = 1'b0;
  logic [WIDTH-1:0]  load_val = '0, limit = '0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  count;
  logic              tc, done;

  prog_counter_n #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up(up), .step(step), .limit(limit),
    .one_shot(one_shot), .count(count), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int tc;
    int done;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference state: plain integers, no width limits.
  int m_count = 0;
  int m_done  = 0;

  task automatic check(input string name, input int idx, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s (cycle %0d): actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  // Next state from the behavioural rules; returns the tc that the edge produces.
  function automatic int model_edge(input int i_en, i_clr, i_load, i_lv, i_up,
                                    i_step, i_limit, i_os);
    int t;
    t = 0;
    if (i_clr != 0) begin
      m_count = 0; m_done = 0;
    end else if (i_load != 0) begin
      m_count = i_lv; m_done = 0;
    end else if (i_en == 0 || i_step == 0 || m_done != 0) begin
      t = 0;
    end else if (i_up != 0) begin
      if (m_count + i_step <= i_limit) m_count = m_count + i_step;
      else begin
        t = 1;
        if (i_os != 0) begin m_count = i_limit; m_done = 1; end
        else m_count = 0;
      end
    end else begin
      if (m_count >= i_step) m_count = m_count - i_step;
      else begin
        t = 1;
        if (i_os != 0) begin m_count = 0; m_done = 1; end
        else m_count = i_limit;
      end
    end
    return t;
  endfunction

  task automatic apply(input int i_en, i_clr, i_load, i_lv, i_up, i_step, i_limit, i_os);
    exp_t e;
    en = i_en[0]; clr = i_clr[0]; load = i_load[0]; load_val = i_lv[WIDTH-1:0];
    up = i_up[0]; step = i_step[STEP_W-1:0]; limit = i_limit[WIDTH-1:0]; one_shot = i_os[0];
    e.tc    = model_edge(i_en, i_clr, i_load, i_lv, i_up, i_step, i_limit, i_os);
    e.count = m_count;
    e.done  = m_done;
    e.idx   = cyc++;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int i_en, i_clr, i_load, i_lv, i_up, i_step, i_limit, i_os);
    @(negedge clk);
    apply(i_en, i_clr, i_load, i_lv, i_up, i_step, i_limit, i_os);
  endtask

  // Direct check of the DUT right after the edge that follows the last cycle() call.
  task automatic expect_now(input string name, input int c, input int t, input int d);
    @(posedge clk);
    #2;
    check({name, ".count"}, cyc, int'(count), c);
    check({name, ".tc"},    cyc, int'(tc),    t);
    check({name, ".done"},  cyc, int'(done),  d);
  endtask

  // Monitor: outputs are valid every clock; compare one prediction per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", e.idx, int'(count), e.count);
        check("tc",    e.idx, int'(tc),    e.tc);
        check("done",  e.idx, int'(done),  e.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, before and after clock edges.
    #1;
    check("reset.count", 0, int'(count), 0);
    check("reset.tc",    0, int'(tc),    0);
    check("reset.done",  0, int'(done),  0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold.count", 0, int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0; m_done = 0;
    apply(0, 1, 0, 0, 1, 1, 5, 0);

    // Wrap, step 1, limit 5: 0..5 then back to 0 with tc.
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, 1, 5, 0);
    expect_now("wrap5", 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 1, 1, 5, 0);

    // One-shot, step 3, limit 10: 3,6,9,10 then frozen; load clears done.
    cycle(1, 1, 0, 0, 1, 3, 10, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 3, 10, 1);
    expect_now("oneshot_term", 10, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 3, 10, 1);
    expect_now("oneshot_frozen", 10, 0, 1);
    cycle(1, 0, 1, 2, 1, 3, 10, 1);
    expect_now("oneshot_reload", 2, 0, 0);

    // Down wrap, step 4, limit 9 from 6: 2,9,5,1,9.
    cycle(1, 0, 1, 6, 0, 4, 9, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 4, 9, 0);
    expect_now("down_wrap", 9, 1, 0);

    // Priority: clr beats load; load beats count; en=0 holds.
    cycle(1, 1, 1, 7, 1, 1, 20, 0);
    expect_now("clr_over_load", 0, 0, 0);
    cycle(1, 0, 1, 7, 1, 1, 20, 0);
    expect_now("load_over_count", 7, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1, 20, 0);
    expect_now("en_low_hold", 7, 0, 0);

    // Full-range: 250+15 exceeds 255 without 8-bit aliasing.
    cycle(1, 0, 1, 250, 1, 15, 255, 0);
    cycle(1, 0, 0, 0, 1, 15, 255, 0);
    expect_now("no_alias", 0, 1, 0);

    // limit 0 in wrap mode: tc held high, count stays 0.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 1, 0, 0);
    expect_now("limit0", 0, 1, 0);

    // Loaded above limit: up terminates at once, down decrements normally.
    cycle(1, 0, 1, 200, 1, 1, 100, 0);
    cycle(1, 0, 0, 0, 1, 1, 100, 0);
    cycle(1, 0, 1, 200, 0, 5, 100, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 5, 100, 0);
    expect_now("above_limit_down", 185, 0, 0);

    // one_shot dropped while done: stays frozen; step 0 holds.
    cycle(1, 0, 1, 1, 0, 2, 50, 1);
    cycle(1, 0, 0, 0, 0, 2, 50, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 2, 50, 0);
    cycle(1, 0, 1, 9, 1, 0, 50, 0);
    cycle(1, 0, 0, 0, 1, 0, 50, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r_lim;
      r_lim = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, MAXV));
      cycle(($urandom_range(0, 7) != 0) ? 1 : 0,
            ($urandom_range(0, 31) == 0) ? 1 : 0,
            ($urandom_range(0, 15) == 0) ? 1 : 0,
            int'($urandom_range(0, MAXV)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << STEP_W) - 1)),
            r_lim,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Async reset mid-count with a tc about to fire.
    cycle(1, 0, 1, 3, 1, 1, 4, 0);
    cycle(1, 0, 0, 0, 1, 1, 4, 0);
    @(posedge clk);
    #3;
    check("pre_reset.count", cyc, int'(count), 4);
    rst_n = 1'b0;
    #1;
    check("async_reset.count", cyc, int'(count), 0);
    check("async_reset.tc",    cyc, int'(tc),    0);
    check("async_reset.done",  cyc, int'(done),  0);
    @(posedge clk);
    #1;
    check("reset_over_tc.tc", cyc, int'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0; m_done = 0;
    apply(1, 0, 0, 0, 1, 1, 4, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 1, 4, 0);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_counter_n.md
Name: prog_counter_n

Overview:
Parameterised programmable counter. It counts up or down by a programmable step against a programmable inclusive limit, and supports synchronous load and clear. It runs in either wrap mode or one-shot mode and reports a terminal-count pulse and a sticky done flag. It replaces the fixed 8-bit datapath in the top-level wrapper; ui_in and uio_in drive the control and data ports.

Parameters:
WIDTH, 8, counter, limit and load-value width in bits.
STEP_W, 4, width of the step input; step range is 0 to 2^STEP_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active low
en  input  1  count enable; no counting when low (clr and load still act)
clr  input  1  synchronous clear
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value loaded when load=1
up  input  1  direction: 1=up, 0=down
step  input  STEP_W  increment/decrement magnitude
limit  input  WIDTH  inclusive upper bound of the count range
one_shot  input  1  mode: 0=wrap, 1=stop at terminal
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
done  output  1  sticky one-shot completion flag (registered)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Assertion immediately forces count=0, tc=0, done=0. Release is sampled on the next clk edge.
- All outputs are registered. A change on any input is visible on outputs one clock after the sampling edge.
- Per-edge priority, highest first:
  - clr=1: count<=0, done<=0, tc<=0.
  - load=1: count<=load_val, done<=0, tc<=0. load_val>limit is accepted as-is.
  - en=0, or step==0, or done=1: count holds, tc<=0.
  - Otherwise a count step, as below.
- Arithmetic uses WIDTH+1 bits internally; there is no silent binary overflow.
- Up (up=1):
  - sum = count+step. If sum<=limit: count<=sum, tc<=0.
  - Else terminal event, tc<=1, and by mode:
    - Wrap: count<=0.
    - One-shot: count<=limit, done<=1.
- Down (up=0):
  - If count>=step: count<=count-step, tc<=0.
  - Else terminal event, tc<=1, and by mode:
    - Wrap: count<=limit.
    - One-shot: count<=0, done<=1.
- tc is high for exactly one cycle per terminal event and coincides with count showing the post-terminal value. Back-to-back events give consecutive tc pulses.
- done stays high until clr or load. While done=1, count is frozen and tc=0.
- one_shot, up, step and limit may change on any cycle; they are sampled on each edge with no pipelining.
- If one_shot is deasserted while done=1, done stays 1 and count stays frozen until clr or load.
- limit=0, wrap mode: every enabled step with step>=1 is a terminal event; count stays 0 and tc stays high continuously.
- count>limit after a load, counting up: the first enabled step is a terminal event.
- count>limit after a load, counting down: decrements normally.
- Reset mid-operation: asserting rst_n low overrides everything asynchronously, including a pending tc.

Test Plan:
- Reset, then en=1, up=1, step=1, limit=5, wrap → count 0,1,2,3,4,5,0. tc=1 only in the cycle count returns to 0; repeats with period 6.
- up=1, step=3, limit=10, one_shot=1 from 0 → count 3,6,9,10. tc pulses once when count=10; done=1 thereafter; count stays 10 with en held high. Then load=1, load_val=2 → count=2, done=0.
- Down, wrap, step=4, limit=9, load 6 → count 6,2,9,5,1,9. tc=1 in each cycle count shows 9 after a wrap.
- Priority: clr=1, load=1, load_val=7 together → count=0. Then load=1, en=1 → count=load_val, no increment that cycle. Then en=0 for 3 cycles → count holds, tc=0.
- WIDTH=8, step=15, limit=255, count=250 up, wrap → terminal event with no 8-bit aliasing; count=0, tc=1.
- Async reset mid-count (count=4, tc about to fire): rst_n low between edges → count=0, tc=0, done=0 immediately, without waiting for a clock edge.
